// File: rtl/fma16_round_pack.sv
// fma16_round_pack: binary16 rounding/packing stage, 2-deep valid/ready pipe.
// in: Ss/Se/Sm/sticky/specials/roundmode; out: result[15:0], flags {NV,OF,UF,NX}.
module fma16_round_pack (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Ss,
  input  logic [6:0]  Se,
  input  logic [33:0] Sm,
  input  logic        sticky_in,
  input  logic        zero_in,
  input  logic        inf_in,
  input  logic        nan_in,
  input  logic        invalid_in,
  input  logic [1:0]  roundmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  localparam logic [1:0] RM_RZ  = 2'd0;
  localparam logic [1:0] RM_RNE = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;

  typedef enum logic [1:0] {
    K_FIN, K_ZERO, K_INF, K_NAN
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic        sign;
    logic        nv;
    logic        ovf;
    logic        tiny;
    logic        nx;
    logic        inc;
    logic [1:0]  rm;
    logic [4:0]  ef;
    logic [9:0]  frac;
  } s1_t;

  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_valid;
  logic s2_adv;

  logic        se_pos;
  logic [6:0]  neg;
  logic [5:0]  sh;
  logic [66:0] wide;
  logic [32:0] mant;
  logic        lost;
  logic        g;
  logic        s;

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;

  // Subnormal shift is 1-Se; shifting {Sm,33'b0} by -Se
  // gives the same alignment without a dead top bit.
  always_comb begin
    se_pos = ~Se[6] & (|Se[5:0]);
    neg    = 7'd0 - Se;
    sh     = (neg > 7'd33) ? 6'd33 : neg[5:0];
    wide   = {Sm, 33'b0} >> sh;
    mant   = se_pos ? Sm[32:0] : wide[66:34];
    lost   = ~se_pos & (|wide[33:0]);
    g      = mant[22];
    s      = (|mant[21:0]) | sticky_in | lost;

    s1_d      = '0;
    s1_d.sign = Ss;
    s1_d.nv   = invalid_in;
    s1_d.ovf  = ~Se[6] & (Se[5:0] >= 6'd31);
    s1_d.tiny = ~se_pos;
    s1_d.nx   = g | s;
    s1_d.rm   = roundmode;
    s1_d.ef   = se_pos ? Se[4:0] : 5'd0;
    s1_d.frac = mant[32:23];

    if (nan_in)       s1_d.kind = K_NAN;
    else if (inf_in)  s1_d.kind = K_INF;
    else if (zero_in) s1_d.kind = K_ZERO;
    else              s1_d.kind = K_FIN;

    unique case (roundmode)
      RM_RZ:  s1_d.inc = 1'b0;
      RM_RNE: s1_d.inc = g & (s | mant[23]);
      RM_RDN: s1_d.inc = Ss & (g | s);
      RM_RUP: s1_d.inc = ~Ss & (g | s);
    endcase
  end

  logic [14:0] sum;
  logic        ovf;
  logic        to_inf;
  logic [15:0] res_d;
  logic [3:0]  flg_d;

  // Fraction carry ripples into the exponent field for free.
  always_comb begin
    sum    = {s1_q.ef, s1_q.frac} + {14'b0, s1_q.inc};
    ovf    = s1_q.ovf | (&sum[14:10]);
    to_inf = (s1_q.rm == RM_RNE)
           | ((s1_q.rm == RM_RUP) & ~s1_q.sign)
           | ((s1_q.rm == RM_RDN) & s1_q.sign);
    res_d  = '0;
    flg_d  = {s1_q.nv, 3'b000};
    unique case (1'b1)
      (s1_q.kind == K_NAN):  res_d = 16'h7E00;
      (s1_q.kind == K_INF):  res_d = {s1_q.sign, 5'h1F, 10'h0};
      (s1_q.kind == K_ZERO): res_d = {s1_q.sign, 15'h0};
      (s1_q.kind == K_FIN): begin
        if (ovf)
          res_d = to_inf ? {s1_q.sign, 15'h7C00}
                         : {s1_q.sign, 15'h7BFF};
        else
          res_d = {s1_q.sign, sum};
        flg_d = {s1_q.nv, ovf,
                 s1_q.tiny & s1_q.nx,
                 s1_q.nx | ovf};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      result    <= 16'h0000;
      flags     <= 4'h0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result <= res_d;
          flags  <= flg_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fma16_round_pack.sv
// tb_fma16_round_pack: table vectors, backpressure/reset sequences,
// and random traffic against an exact-arithmetic rounding model.
module tb_fma16_round_pack;

  localparam logic [1:0] RZ  = 2'd0;
  localparam logic [1:0] RNE = 2'd1;
  localparam logic [1:0] RDN = 2'd2;
  localparam logic [1:0] RUP = 2'd3;
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        Ss;
  logic [6:0]  Se;
  logic [33:0] Sm;
  logic        sticky_in;
  logic        zero_in;
  logic        inf_in;
  logic        nan_in;
  logic        invalid_in;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fma16_round_pack dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Ss(Ss), .Se(Se), .Sm(Sm),
    .sticky_in(sticky_in), .zero_in(zero_in),
    .inf_in(inf_in), .nan_in(nan_in),
    .invalid_in(invalid_in), .roundmode(roundmode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  typedef struct {
    logic        ss;
    logic [6:0]  se;
    logic [33:0] sm;
    logic        st;
    logic        z;
    logic        inf;
    logic        nan;
    logic        inv;
    logic [1:0]  rm;
    logic [15:0] er;
    logic [3:0]  ef;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(
    logic ss, int se, logic [33:0] sm, logic st,
    logic z, logic inf, logic nan, logic inv,
    logic [1:0] rm, logic [15:0] er, logic [3:0] ef);
    vec_t v;
    v.ss = ss; v.se = 7'(se); v.sm = sm; v.st = st;
    v.z = z; v.inf = inf; v.nan = nan; v.inv = inv;
    v.rm = rm; v.er = er; v.ef = ef;
    return v;
  endfunction

  // Exact value Sm*2^(Se-48) expressed in units of the target ulp,
  // then rounded and re-encoded as (biased exponent - 1)*1024 + q.
  function automatic logic [19:0] model(vec_t v);
    int e, eff, k, enc;
    logic [127:0] m, q, rem, half;
    logic nx, up, ovf, uf, toinf;
    logic [14:0] mag;
    if (v.nan) return {v.inv, 3'b000, 16'h7E00};
    if (v.inf) return {v.inv, 3'b000, v.ss, 5'h1F, 10'h0};
    if (v.z)   return {v.inv, 3'b000, v.ss, 15'h0};
    e    = int'($signed(v.se));
    eff  = (e >= 1) ? e : 1;
    k    = 23 + eff - e;
    m    = 128'(v.sm);
    q    = m >> k;
    rem  = m - (q << k);
    half = 128'd1 << (k - 1);
    nx   = (rem != 0) || v.st;
    case (v.rm)
      RZ:      up = 1'b0;
      RNE:     up = (rem > half) || ((rem == half) && (v.st || q[0]));
      RDN:     up = v.ss && nx;
      default: up = !v.ss && nx;
    endcase
    q     = q + 128'(up);
    enc   = (eff - 1) * 1024 + int'(q[11:0]);
    ovf   = (e >= 31) || (enc >= 31 * 1024);
    uf    = (e <= 0) && nx;
    toinf = (v.rm == RNE) || (v.rm == RUP && !v.ss) || (v.rm == RDN && v.ss);
    if (ovf) mag = toinf ? 15'h7C00 : 15'h7BFF;
    else     mag = enc[14:0];
    return {v.inv, ovf, uf, nx || ovf, v.ss, mag};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int t;
    v.ss = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 7) begin
      t = int'($urandom_range(0, 50)) - 15;
      v.se = 7'(t);
    end else begin
      v.se = 7'($urandom_range(0, 127));
    end
    v.sm = {1'b1, 1'($urandom()), 32'($urandom())};
    if ($urandom_range(0, 2) == 0)
      v.sm[22:0] = ($urandom_range(0, 1) == 1) ? 23'h400000 : 23'h0;
    if ($urandom_range(0, 7) == 0) v.sm[32:23] = 10'h3FF;
    v.st  = ($urandom_range(0, 3) == 0);
    v.z   = ($urandom_range(0, 11) == 0);
    v.inf = ($urandom_range(0, 11) == 0);
    v.nan = ($urandom_range(0, 11) == 0);
    v.inv = ($urandom_range(0, 7) == 0);
    v.rm  = 2'($urandom_range(0, 3));
    v.er  = 16'h0;
    v.ef  = 4'h0;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v, logic vld);
    Ss = v.ss; Se = v.se; Sm = v.sm; sticky_in = v.st;
    zero_in = v.z; inf_in = v.inf; nan_in = v.nan;
    invalid_in = v.inv; roundmode = v.rm; in_valid = vld;
  endtask

  task automatic run_vec(vec_t v, string name);
    bit acc;
    drive(v, 1'b1);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      chk({name, " accept"}, 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    chk({name, " lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, " lat2"}, 32'(out_valid), 32'd1);
    chk({name, " result"}, 32'(result), 32'(v.er));
    chk({name, " flags"}, 32'(flags), 32'(v.ef));
    @(posedge clk); #1;
  endtask

  task automatic bp(bit do_reset);
    int idx[4] = '{0, 2, 3, 12};
    int k = 0;
    int got = 0;
    int stale = 0;
    bit acc;
    bit fin = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (k < 4) drive(vecs[idx[k]], 1'b1);
      else in_valid = 1'b0;
      if (c >= 5) out_ready = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 4) begin
        chk("bp accepts", 32'(k), 32'd2);
        chk("bp in_ready", 32'(in_ready), 32'd0);
        chk("bp hold valid", 32'(out_valid), 32'd1);
        chk("bp hold result", {12'h0, flags, result},
            {12'h0, vecs[idx[0]].ef, vecs[idx[0]].er});
      end
      if (out_valid && out_ready) begin
        if (got < 4)
          chk($sformatf("bp order %0d", got), {12'h0, flags, result},
              {12'h0, vecs[idx[got]].ef, vecs[idx[got]].er});
        got++;
      end
      if (c == 4 && do_reset) begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result", {12'h0, flags, result}, 32'd0);
        reset_n = 1'b1;
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (acc) k++;
        if (got == 4) fin = 1'b1;
      end
    end
    if (!do_reset) begin
      chk("bp all out", 32'(got), 32'd4);
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 10; c++) begin
        if (out_valid) stale++;
        @(negedge clk);
      end
      chk("rst no stale", 32'(stale), 32'd0);
      @(posedge clk); #1;
      run_vec(vecs[1], "post-rst");
    end
  endtask

  task automatic rand_run(int n);
    vec_t rv;
    logic [19:0] q_exp[$];
    logic [15:0] held_r;
    logic [3:0]  held_f;
    bit held = 1'b0;
    for (int c = 0; c < n; c++) begin
      rv = rand_vec();
      drive(rv, $urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (held)
        chk("rand hold", {11'h0, out_valid, flags, result},
            {11'h0, 1'b1, held_f, held_r});
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) chk("rand spurious", 32'd1, 32'd0);
        else chk("rand out", {12'h0, flags, result}, {12'h0, q_exp.pop_front()});
      end
      if (in_valid && in_ready) q_exp.push_back(model(rv));
      held   = out_valid && !out_ready;
      held_r = result;
      held_f = flags;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q_exp.size() == 0) chk("drain spurious", 32'd1, 32'd0);
        else chk("drain out", {12'h0, flags, result}, {12'h0, q_exp.pop_front()});
      end
      @(posedge clk); #1;
    end
    chk("drain empty", 32'(q_exp.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(0, 15, 34'h200000000, 0, 0, 0, 0, 0, RNE, 16'h3C00, 4'h0);
    vecs[1]  = mk(0, 15, 34'h200400000, 0, 0, 0, 0, 0, RNE, 16'h3C00, 4'h1);
    vecs[2]  = mk(0, 15, 34'h200400000, 0, 0, 0, 0, 0, RUP, 16'h3C01, 4'h1);
    vecs[3]  = mk(1, 15, 34'h200400000, 0, 0, 0, 0, 0, RDN, 16'hBC01, 4'h1);
    vecs[4]  = mk(0, 31, 34'h200000000, 0, 0, 0, 0, 0, RNE, 16'h7C00, 4'h5);
    vecs[5]  = mk(0, 31, 34'h200000000, 0, 0, 0, 0, 0, RZ,  16'h7BFF, 4'h5);
    vecs[6]  = mk(1, 31, 34'h200000000, 0, 0, 0, 0, 0, RUP, 16'hFBFF, 4'h5);
    vecs[7]  = mk(0, 30, 34'h3FFE00000, 0, 0, 0, 0, 0, RNE, 16'h7C00, 4'h5);
    vecs[8]  = mk(0, 0,  34'h200000000, 0, 0, 0, 0, 0, RNE, 16'h0200, 4'h0);
    vecs[9]  = mk(0, -10, 34'h200000000, 0, 0, 0, 0, 0, RNE, 16'h0000, 4'h3);
    vecs[10] = mk(0, -10, 34'h200000000, 0, 0, 0, 0, 0, RUP, 16'h0001, 4'h3);
    vecs[11] = mk(0, 15, 34'h200000000, 0, 0, 0, 1, 1, RNE, 16'h7E00, 4'h8);
    vecs[12] = mk(1, 15, 34'h200000000, 0, 0, 1, 0, 0, RNE, 16'hFC00, 4'h0);
    vecs[13] = mk(1, 15, 34'h200000000, 0, 1, 0, 0, 0, RNE, 16'h8000, 4'h0);
    vecs[14] = mk(0, 0,  34'h3FF800000, 0, 0, 0, 0, 0, RNE, 16'h0400, 4'h3);
    vecs[15] = mk(0, -64, 34'h200000000, 0, 0, 0, 0, 0, RUP, 16'h0001, 4'h3);
    vecs[16] = mk(0, 15, 34'h200000000, 1, 0, 0, 0, 0, RUP, 16'h3C01, 4'h1);
    vecs[17] = mk(1, 15, 34'h200000000, 1, 0, 0, 0, 0, RZ,  16'hBC00, 4'h1);
    vecs[18] = mk(1, 15, 34'h200C00000, 0, 0, 0, 0, 0, RNE, 16'hBC02, 4'h1);
    vecs[19] = mk(1, 31, 34'h200000000, 0, 0, 0, 0, 0, RDN, 16'hFC00, 4'h5);
    vecs[20] = mk(0, 15, 34'h200000000, 0, 1, 1, 1, 0, RNE, 16'h7E00, 4'h0);

    reset_n = 1'b0;
    out_ready = 1'b0;
    drive(vecs[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    bp(1'b0);
    bp(1'b1);
    rand_run(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
